// File: rtl/esi_cosim_pkg.sv
// esi_cosim_pkg: shared state encoding and default timing constants for the cosim reset sequencer
package esi_cosim_pkg;
  typedef enum logic [2:0] {
    ST_HOLD,
    ST_WAIT_ACK,
    ST_RUN,
    ST_DONE,
    ST_ERROR
  } seq_state_e;
  localparam int unsigned HOLD_CYCLES_DEF = 4;
  localparam int unsigned ACK_TIMEOUT_DEF = 1024;
endpackage

// File: rtl/cosim_cycle_counter.sv
// cosim_cycle_counter: clearable, enabled run counter with a latched compare value; hit flags the final counted cycle
module cosim_cycle_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic         load_i,
  input  logic [W-1:0] cmp_i,
  output logic [W-1:0] count_o,
  output logic         hit_o
);
  logic [W-1:0] count_q, cmp_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      cmp_q   <= '0;
    end else begin
      if (load_i) cmp_q <= cmp_i;
      if (clr_i) count_q <= '0;
      else if (en_i) count_q <= count_q + W'(1);
    end
  end
  // a zero compare value means unlimited, so it never hits
  assign hit_o   = (cmp_q != '0) && (count_q == cmp_q - W'(1));
  assign count_o = count_q;
endmodule

// File: rtl/esi_cosim_reset_seq.sv
// esi_cosim_reset_seq: reset hold, DUT acknowledge handshake with timeout, and bounded run-length sequencing
module esi_cosim_reset_seq
  import esi_cosim_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 reset_req,
  input  logic                 dut_rst_ack,
  input  logic [CNT_WIDTH-1:0] cycle_limit,
  output logic                 dut_rst,
  output logic                 running,
  output logic                 done,
  output logic                 timeout_err,
  output logic [CNT_WIDTH-1:0] cycle_count
);
  localparam int unsigned HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned WW = ACK_TIMEOUT > 1 ? $clog2(ACK_TIMEOUT) : 1;
  seq_state_e state_q;
  logic [HW-1:0] hold_cnt_q;
  logic [WW-1:0] wait_cnt_q;
  logic ack_go, wait_exp, hit;
  assign ack_go   = (state_q == ST_WAIT_ACK) && dut_rst_ack;
  assign wait_exp = (ACK_TIMEOUT != 0) && (wait_cnt_q == WW'(ACK_TIMEOUT - 1));
  always_ff @(posedge clk) begin
    if (rst || reset_req) begin
      state_q    <= ST_HOLD;
      hold_cnt_q <= '0;
      wait_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_HOLD:
          if (hold_cnt_q == HW'(HOLD_CYCLES - 1)) begin
            state_q    <= ST_WAIT_ACK;
            wait_cnt_q <= '0;
          end else hold_cnt_q <= hold_cnt_q + HW'(1);
        ST_WAIT_ACK:
          if (dut_rst_ack) state_q <= ST_RUN;
          else if (wait_exp) state_q <= ST_ERROR;
          else wait_cnt_q <= wait_cnt_q + WW'(1);
        ST_RUN: if (hit) state_q <= ST_DONE;
        default: ;
      endcase
    end
  end
  // the run limit is captured only at the moment RUN is entered
  cosim_cycle_counter #(.W(CNT_WIDTH)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (reset_req || ack_go),
    .en_i   (state_q == ST_RUN),
    .load_i (ack_go),
    .cmp_i  (cycle_limit),
    .count_o(cycle_count),
    .hit_o  (hit)
  );
  assign dut_rst     = (state_q == ST_HOLD) || (state_q == ST_WAIT_ACK) || (state_q == ST_ERROR);
  assign running     = state_q == ST_RUN;
  assign done        = state_q == ST_DONE;
  assign timeout_err = state_q == ST_ERROR;
endmodule

// File: tb/tb_esi_cosim_reset_seq.sv
// tb_esi_cosim_reset_seq: directed vector table plus hand sequences for timeout, ack priority and wrap
module tb_esi_cosim_reset_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, reset_req, dut_rst_ack;
  logic [3:0] cycle_limit;
  logic dut_rst, running, done, timeout_err;
  logic [3:0] cycle_count;
  esi_cosim_reset_seq #(.HOLD_CYCLES(4), .ACK_TIMEOUT(16), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .reset_req(reset_req), .dut_rst_ack(dut_rst_ack),
    .cycle_limit(cycle_limit), .dut_rst(dut_rst), .running(running), .done(done),
    .timeout_err(timeout_err), .cycle_count(cycle_count)
  );
  typedef struct {
    logic rst, req, ack;
    logic [3:0] lim;
    logic dr, run, dn, er;
    logic [3:0] cnt;
  } vec_t;
  vec_t tbl[$];
  int errors = 0;
  int checks = 0;
  function automatic void add(input logic r, q, a, input logic [3:0] l,
                              input logic dr, run, dn, er, input logic [3:0] cnt);
    vec_t v;
    v.rst = r; v.req = q; v.ack = a; v.lim = l;
    v.dr = dr; v.run = run; v.dn = dn; v.er = er; v.cnt = cnt;
    tbl.push_back(v);
  endfunction
  task automatic step(input logic r, q, a, input logic [3:0] l);
    @(negedge clk);
    rst = r; reset_req = q; dut_rst_ack = a; cycle_limit = l;
    @(posedge clk);
    #1;
  endtask
  task automatic expect_out(input string name, input logic dr, run, dn, er, input logic [3:0] cnt);
    checks++;
    if ({dut_rst, running, done, timeout_err, cycle_count} !== {dr, run, dn, er, cnt}) begin
      errors++;
      $display("FAIL %s: got dut_rst=%b running=%b done=%b timeout_err=%b count=%0d, want %b %b %b %b %0d",
               name, dut_rst, running, done, timeout_err, cycle_count, dr, run, dn, er, cnt);
    end
  endtask
  initial begin
    rst = 1'b1; reset_req = 1'b0; dut_rst_ack = 1'b0; cycle_limit = 4'd0;
    add(1, 0, 1, 10, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 1, 10, 1, 0, 0, 0, 0);
    add(0, 0, 1, 10, 0, 1, 0, 0, 0);
    for (int i = 1; i < 10; i++) add(0, 0, 1, 10, 0, 1, 0, 0, 4'(i));
    add(0, 0, 1, 10, 0, 0, 1, 0, 10);
    for (int i = 0; i < 2; i++) add(0, 0, 0, 10, 0, 0, 1, 0, 10);
    add(0, 1, 0, 3, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 3, 1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) add(0, 0, 0, 3, 1, 0, 0, 0, 0);
    add(0, 0, 1, 10, 0, 1, 0, 0, 0);
    for (int i = 1; i < 4; i++) add(0, 0, 0, 10, 0, 1, 0, 0, 4'(i));
    add(0, 1, 1, 5, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 1, 5, 1, 0, 0, 0, 0);
    add(0, 0, 1, 5, 0, 1, 0, 0, 0);
    for (int i = 1; i < 5; i++) add(0, 0, 1, 9, 0, 1, 0, 0, 4'(i));
    add(0, 0, 1, 9, 0, 0, 1, 0, 5);
    add(1, 1, 1, 9, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 1, 1, 9, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 1, 9, 1, 0, 0, 0, 0);
    add(0, 0, 1, 9, 0, 1, 0, 0, 0);
    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].req, tbl[i].ack, tbl[i].lim);
      expect_out($sformatf("vec%0d", i), tbl[i].dr, tbl[i].run, tbl[i].dn, tbl[i].er, tbl[i].cnt);
    end
    step(0, 1, 0, 0);
    expect_out("to_req", 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0);
      expect_out($sformatf("to_hold%0d", i), 1, 0, 0, 0, 0);
    end
    for (int i = 1; i < 16; i++) begin
      step(0, 0, 0, 0);
      expect_out($sformatf("to_wait%0d", i), 1, 0, 0, 0, 0);
    end
    step(0, 0, 0, 0);
    expect_out("to_err", 1, 0, 0, 1, 0);
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 1, 0);
      expect_out($sformatf("to_sticky%0d", i), 1, 0, 0, 1, 0);
    end
    step(0, 1, 0, 0);
    expect_out("err_clear", 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    for (int i = 1; i < 16; i++) step(0, 0, 0, 0);
    expect_out("pri_wait", 1, 0, 0, 0, 0);
    step(0, 0, 1, 0);
    expect_out("ack_priority", 0, 1, 0, 0, 0);
    for (int i = 1; i < 19; i++) begin
      step(0, 0, 1, 0);
      expect_out($sformatf("wrap%0d", i), 0, 1, 0, 0, 4'(i % 16));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
